// File: rtl/da4_update_scheduler.sv
// PMOD DA4 update scheduler: round-robin arbitration of channel updates into 32-bit SPI DAC words.
// Define DA4_REF_INIT_EN to send the internal-reference setup frame once after every reset.
module da4_update_scheduler #(
  parameter int          NREQ       = 4,
  parameter logic [31:0] SETUP_WORD = 32'h0800_0001,
  parameter logic [3:0]  CMD_WR_UPD = 4'h3
) (
  input  logic                 clk100mhz,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [3*NREQ-1:0]    req_chan,
  input  logic [12*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic [31:0]          cmd_word,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  input  logic                 spi_done,
  output logic                 init_done,
  output logic                 busy
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [LW-1:0] LAST_RST = LW'(NREQ - 1);

`ifdef DA4_REF_INIT_EN
  typedef enum logic [2:0] {INIT_SEND, INIT_WAIT, IDLE, SEND, WAIT} state_t;
  localparam state_t RESET_STATE = INIT_SEND;
`else
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t          state;
  logic [LW-1:0]   last;
  logic [LW-1:0]   win;
  logic [LW-1:0]   cand;
  logic            found;
  logic [NREQ-1:0] win_onehot;
  logic [2:0]      chan_a [NREQ];
  logic [11:0]     data_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign chan_a[i] = req_chan[3*i +: 3];
    assign data_a[i] = req_data[12*i +: 12];
  end

  // Winner is the first requester after the previous grant, wrapping modulo NREQ.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    win        = last;
    cand       = last;
    found      = 1'b0;
    win_onehot = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = LW'((int'(last) + i) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    win_onehot[win] = 1'b1;
  end

  always_ff @(posedge clk100mhz or negedge rst_n) begin
    // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
    if (!rst_n) begin
      state     <= RESET_STATE;
      last      <= LAST_RST;
      gnt       <= '0;
      cmd_word  <= '0;
      cmd_valid <= 1'b0;
      init_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      gnt <= '0;
      case (state)
`ifdef DA4_REF_INIT_EN
        INIT_SEND: begin
          if (!cmd_valid) begin
            cmd_word  <= SETUP_WORD;
            cmd_valid <= 1'b1;
            busy      <= 1'b1;
          end else if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= INIT_WAIT;
          end
        end
        INIT_WAIT: begin
          if (spi_done) begin
            init_done <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
`endif
        IDLE: begin
`ifndef DA4_REF_INIT_EN
          init_done <= 1'b1;
`endif
          // Grants only start once init_done is already visible to the requesters.
          if (init_done && (req != '0)) begin
            gnt       <= win_onehot;
            last      <= win;
            cmd_word  <= {4'h0, CMD_WR_UPD, 1'b0, chan_a[win], data_a[win], 8'h00};
            cmd_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (spi_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= RESET_STATE;
      endcase
    end
  end

endmodule
